// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, gated 100 Hz tick,
// IDLE/RUN/PAUSE/VIEW mode FSM, lap slot allocation and display select.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int TICK_DIV           = 500000,
    parameter int VIEW_TIMEOUT_TICKS = 300
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       btn_view,
    output logic       tick_100hz,
    output logic       count_clear,
    output logic       lap_wr,
    output logic [1:0] lap_slot,
    output logic [1:0] disp_sel,
    output logic       running,
    output logic [1:0] laps_used
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int VW = $clog2(VIEW_TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [VW-1:0] VIEW_LAST = VW'(VIEW_TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, VIEW} state_t;

    // Button index: 0 start, 1 lap, 2 clear, 3 view
    logic [3:0]    sync1_q, sync2_q, level_q, level_d, press_q, press_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [DW-1:0] div_q, div_d;
    logic [VW-1:0] vcnt_q;
    state_t        state_q;
    logic          ret_pause_q;
    logic          tick_q, count_clear_q, lap_wr_q, running_q;
    logic [1:0]    lap_slot_q, disp_sel_q, laps_used_q;
    logic          base_tick, p_start, p_lap, p_clear, p_view, clr_go;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]   = '0;
            level_d[i] = level_q[i];
            press_d[i] = 1'b0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Strict priority: only the highest coincident press survives
    assign p_clear   = press_q[2];
    assign p_start   = press_q[0] & ~press_q[2];
    assign p_lap     = press_q[1] & ~press_q[2] & ~press_q[0];
    assign p_view    = press_q[3] & ~press_q[2] & ~press_q[0] & ~press_q[1];
    assign clr_go    = p_clear && (state_q == PAUSE || state_q == VIEW);
    assign base_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (clr_go || base_tick) div_d = '0;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= {btn_view, btn_clear, btn_lap, btn_start};
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            div_q   <= div_d;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ret_pause_q   <= 1'b0;
            vcnt_q        <= '0;
            tick_q        <= 1'b0;
            count_clear_q <= 1'b0;
            lap_wr_q      <= 1'b0;
            lap_slot_q    <= 2'd0;
            disp_sel_q    <= 2'd0;
            running_q     <= 1'b0;
            laps_used_q   <= 2'd0;
        end else begin
            tick_q        <= base_tick && (state_q == RUN);
            count_clear_q <= 1'b0;
            lap_wr_q      <= 1'b0;
            lap_slot_q    <= 2'd0;
            case (state_q)
                IDLE: begin
                    if (p_start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (p_view && laps_used_q != 2'd0) begin
                        state_q     <= VIEW;
                        disp_sel_q  <= 2'd1;
                        ret_pause_q <= 1'b0;
                        vcnt_q      <= '0;
                    end
                end
                RUN: begin
                    if (p_start) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (p_lap && laps_used_q != 2'd3) begin
                        lap_wr_q    <= 1'b1;
                        lap_slot_q  <= laps_used_q + 2'd1;
                        laps_used_q <= laps_used_q + 2'd1;
                    end
                end
                PAUSE: begin
                    if (p_clear) begin
                        state_q       <= IDLE;
                        count_clear_q <= 1'b1;
                        laps_used_q   <= 2'd0;
                    end else if (p_start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (p_view && laps_used_q != 2'd0) begin
                        state_q     <= VIEW;
                        disp_sel_q  <= 2'd1;
                        ret_pause_q <= 1'b1;
                        vcnt_q      <= '0;
                    end
                end
                default: begin
                    if (p_clear) begin
                        state_q       <= IDLE;
                        count_clear_q <= 1'b1;
                        laps_used_q   <= 2'd0;
                        disp_sel_q    <= 2'd0;
                    end else if (p_start) begin
                        state_q    <= RUN;
                        running_q  <= 1'b1;
                        disp_sel_q <= 2'd0;
                    end else if (p_view) begin
                        vcnt_q <= '0;
                        if (disp_sel_q == laps_used_q) begin
                            disp_sel_q <= 2'd0;
                            state_q    <= ret_pause_q ? PAUSE : IDLE;
                        end else begin
                            disp_sel_q <= disp_sel_q + 2'd1;
                        end
                    end else if (base_tick) begin
                        if (vcnt_q == VIEW_LAST) begin
                            disp_sel_q <= 2'd0;
                            state_q    <= ret_pause_q ? PAUSE : IDLE;
                        end else begin
                            vcnt_q <= vcnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign tick_100hz  = tick_q;
    assign count_clear = count_clear_q;
    assign lap_wr      = lap_wr_q;
    assign lap_slot    = lap_slot_q;
    assign disp_sel    = disp_sel_q;
    assign running     = running_q;
    assign laps_used   = laps_used_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with small debounce/divider/timeout values.
module tb_stopwatch_ctrl;
    logic       clk_50M = 1'b0;
    logic       reset;
    logic       btn_start, btn_lap, btn_clear, btn_view;
    logic       tick_100hz, count_clear, lap_wr, running;
    logic [1:0] lap_slot, disp_sel, laps_used;

    int total = 0;
    int bad   = 0;
    int n_lapwr, n_clr, n_tick;
    logic [1:0] last_slot;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(10),
        .VIEW_TIMEOUT_TICKS(5)
    ) dut (
        .clk_50M(clk_50M), .reset(reset),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear), .btn_view(btn_view),
        .tick_100hz(tick_100hz), .count_clear(count_clear), .lap_wr(lap_wr),
        .lap_slot(lap_slot), .disp_sel(disp_sel), .running(running), .laps_used(laps_used)
    );

    always #5 clk_50M = ~clk_50M;

    function automatic logic [9:0] all_outs();
        return {tick_100hz, count_clear, lap_wr, lap_slot, disp_sel, running, laps_used};
    endfunction

    task automatic drive(input logic [3:0] m);
        btn_start = m[0]; btn_lap = m[1]; btn_clear = m[2]; btn_view = m[3];
    endtask

    task automatic mon();
        if (lap_wr) begin n_lapwr++; last_slot = lap_slot; end
        if (count_clear) n_clr++;
        if (tick_100hz) n_tick++;
    endtask

    // mask bits: 0 start, 1 lap, 2 clear, 3 view
    task automatic press(input logic [3:0] m);
        n_lapwr = 0; n_clr = 0; n_tick = 0; last_slot = 2'd0;
        @(negedge clk_50M); drive(m);
        repeat (8) begin @(negedge clk_50M); mon(); end
        drive(4'b0);
        repeat (10) begin @(negedge clk_50M); mon(); end
    endtask

    task automatic test_reset();
        reset = 1'b1; drive(4'b0);
        repeat (3) @(negedge clk_50M);
        total++;
        if (all_outs() !== 10'd0) begin bad++; $display("FAIL reset_outs got=%b want=0", all_outs()); end
        reset = 1'b0;
        repeat (3) @(negedge clk_50M);
        total++;
        if (all_outs() !== 10'd0) begin bad++; $display("FAIL post_reset_outs got=%b want=0", all_outs()); end
    endtask

    task automatic test_debounce();
        int found;
        @(negedge clk_50M); btn_start = 1'b1;
        repeat (3) @(negedge clk_50M);
        btn_start = 1'b0;
        repeat (12) @(negedge clk_50M);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL glitch_ignored running=%b want=0", running); end
        btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_50M);
            if (k == 6) begin
                total++;
                if (running !== 1'b0) begin bad++; $display("FAIL latency_k6 running=%b want=0", running); end
            end
            if (k == 7) begin
                total++;
                if (running !== 1'b1) begin bad++; $display("FAIL latency_k7 running=%b want=1", running); end
            end
        end
        btn_start = 1'b0;
        repeat (10) @(negedge clk_50M);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk_50M);
            if (tick_100hz) found = 1;
        end
        total++;
        if (found != 1) begin bad++; $display("FAIL tick_seen got=%0d want=1", found); end
        n_tick = 0;
        repeat (9) begin @(negedge clk_50M); if (tick_100hz) n_tick++; end
        total++;
        if (n_tick != 0) begin bad++; $display("FAIL tick_gap got=%0d want=0", n_tick); end
        @(negedge clk_50M);
        total++;
        if (tick_100hz !== 1'b1) begin bad++; $display("FAIL tick_period tick=%b want=1", tick_100hz); end
    endtask

    task automatic test_lap();
        for (int n = 1; n <= 4; n++) begin
            press(4'b0010);
            total++;
            if (n <= 3) begin
                if (n_lapwr != 1 || last_slot !== 2'(n) || laps_used !== 2'(n)) begin
                    bad++;
                    $display("FAIL lap_%0d wr=%0d slot=%0d used=%0d want wr=1 slot=%0d used=%0d",
                             n, n_lapwr, last_slot, laps_used, n, n);
                end
            end else if (n_lapwr != 0 || laps_used !== 2'd3) begin
                bad++;
                $display("FAIL lap_full wr=%0d used=%0d want wr=0 used=3", n_lapwr, laps_used);
            end
        end
        total++;
        if (lap_slot !== 2'd0) begin bad++; $display("FAIL lap_slot_idle got=%0d want=0", lap_slot); end
    endtask

    task automatic test_clear();
        press(4'b0100);
        total++;
        if (running !== 1'b1 || laps_used !== 2'd3 || n_clr != 0) begin
            bad++; $display("FAIL clear_in_run run=%b used=%0d clr=%0d want 1 3 0", running, laps_used, n_clr);
        end
        press(4'b0001);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL run_to_pause running=%b want=0", running); end
        press(4'b0100);
        total++;
        if (n_clr != 1 || laps_used !== 2'd0 || n_lapwr != 0) begin
            bad++; $display("FAIL pause_clear clr=%0d used=%0d wr=%0d want 1 0 0", n_clr, laps_used, n_lapwr);
        end
        n_tick = 0;
        repeat (30) begin @(negedge clk_50M); if (tick_100hz) n_tick++; end
        total++;
        if (n_tick != 0 || running !== 1'b0) begin
            bad++; $display("FAIL idle_silent ticks=%0d run=%b want 0 0", n_tick, running);
        end
    endtask

    task automatic test_recall();
        int waited;
        press(4'b0001); press(4'b0010); press(4'b0010); press(4'b0001);
        total++;
        if (running !== 1'b0 || laps_used !== 2'd2) begin
            bad++; $display("FAIL recall_setup run=%b used=%0d want 0 2", running, laps_used);
        end
        press(4'b1000);
        total++;
        if (disp_sel !== 2'd1) begin bad++; $display("FAIL view_1 disp=%0d want=1", disp_sel); end
        press(4'b1000);
        total++;
        if (disp_sel !== 2'd2) begin bad++; $display("FAIL view_2 disp=%0d want=2", disp_sel); end
        press(4'b1000);
        total++;
        if (disp_sel !== 2'd0 || running !== 1'b0 || laps_used !== 2'd2) begin
            bad++; $display("FAIL view_exit disp=%0d run=%b used=%0d want 0 0 2", disp_sel, running, laps_used);
        end
        @(negedge clk_50M); btn_view = 1'b1;
        waited = 0;
        while (disp_sel !== 2'd1 && waited < 20) begin @(negedge clk_50M); waited++; end
        btn_view = 1'b0;
        total++;
        if (disp_sel !== 2'd1) begin bad++; $display("FAIL timeout_entry disp=%0d want=1", disp_sel); end
        repeat (40) @(negedge clk_50M);
        total++;
        if (disp_sel !== 2'd1) begin bad++; $display("FAIL timeout_early disp=%0d want=1", disp_sel); end
        repeat (10) @(negedge clk_50M);
        total++;
        if (disp_sel !== 2'd0 || running !== 1'b0 || laps_used !== 2'd2) begin
            bad++; $display("FAIL timeout_exit disp=%0d run=%b used=%0d want 0 0 2", disp_sel, running, laps_used);
        end
    endtask

    task automatic test_simultaneous();
        press(4'b0001);
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL sim_resume running=%b want=1", running); end
        press(4'b0011);
        total++;
        if (running !== 1'b0 || n_lapwr != 0 || laps_used !== 2'd2) begin
            bad++; $display("FAIL start_lap run=%b wr=%0d used=%0d want 0 0 2", running, n_lapwr, laps_used);
        end
        press(4'b0101);
        total++;
        if (running !== 1'b0 || laps_used !== 2'd0 || n_clr != 1) begin
            bad++; $display("FAIL clear_start run=%b used=%0d clr=%0d want 0 0 1", running, laps_used, n_clr);
        end
    endtask

    task automatic test_reset_mid();
        press(4'b0001); press(4'b0010); press(4'b0010); press(4'b0001);
        press(4'b1000); press(4'b1000);
        total++;
        if (disp_sel !== 2'd2) begin bad++; $display("FAIL mid_setup disp=%0d want=2", disp_sel); end
        @(negedge clk_50M); btn_lap = 1'b1;
        repeat (4) @(negedge clk_50M);
        #2 reset = 1'b1;
        #1;
        total++;
        if (all_outs() !== 10'd0) begin bad++; $display("FAIL async_reset got=%b want=0", all_outs()); end
        btn_lap = 1'b0;
        repeat (3) @(negedge clk_50M);
        reset = 1'b0;
        repeat (12) @(negedge clk_50M);
        total++;
        if (all_outs() !== 10'd0) begin bad++; $display("FAIL after_reset got=%b want=0", all_outs()); end
        press(4'b1000);
        total++;
        if (disp_sel !== 2'd0) begin bad++; $display("FAIL idle_view disp=%0d want=0", disp_sel); end
        reset = 1'b1; btn_start = 1'b1;
        repeat (3) @(negedge clk_50M);
        reset = 1'b0;
        repeat (12) @(negedge clk_50M);
        btn_start = 1'b0;
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL held_through_reset running=%b want=1", running); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_lap();
        test_clear();
        test_recall();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
